xbar_route_sequencer: RTL and testbench

XBAR_ROUTE_SEQUENCER -- requirements
Module: xbar_route_sequencer

---
 rtl/xbar_route_sequencer_pkg.sv | 27 ++
 rtl/xbar_route_sequencer_if.sv | 32 +++
 rtl/xbar_route_sequencer_route_fifo.sv | 51 +++++
 rtl/xbar_route_sequencer.sv | 105 ++++++++++
 tb/tb_xbar_route_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_route_sequencer_pkg.sv
// Shared types and helpers for the crossbar route sequencer: FSM state enum,
// select-field widths and control-word packing.
package xbar_seq_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE} seq_state_e;

  localparam int MAX_CW = 256;

  // A single-entry dimension still needs a 1-bit select field.
  function automatic int field_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // input_sel occupies the top iw bits, output_sel the next ow bits, rest zero.
  function automatic logic [MAX_CW-1:0] pack_control(int cw, int iw, int ow,
                                                     logic [31:0] in_sel,
                                                     logic [31:0] out_sel);
    logic [MAX_CW-1:0] in_w;
    logic [MAX_CW-1:0] out_w;
    in_w        = '0;
    out_w       = '0;
    in_w[31:0]  = in_sel;
    out_w[31:0] = out_sel;
    return (in_w << (cw - iw)) | (out_w << (cw - iw - ow));
  endfunction

endpackage

// File: rtl/xbar_route_sequencer_if.sv
// Route request, crossbar control and status signals of the route sequencer.
// master = requester/crossbar side, slave = sequencer.
interface xbar_route_sequencer_if
  import xbar_seq_pkg::*;
#(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int CNT_WIDTH         = 8
);
  localparam int MSG_W = field_w(N_INPUTS) + field_w(N_OUTPUTS) + CNT_WIDTH;

  logic [MSG_W-1:0]             route_msg;
  logic                         route_val;
  logic                         route_rdy;
  logic [CONTROL_BIT_WIDTH-1:0] control;
  logic                         control_val;
  logic                         control_rdy;
  logic                         xfer_fire;
  logic                         busy;
  logic [CNT_WIDTH-1:0]         remaining;

  modport master (
    output route_msg, route_val, control_rdy, xfer_fire,
    input  route_rdy, control, control_val, busy, remaining
  );

  modport slave (
    input  route_msg, route_val, control_rdy, xfer_fire,
    output route_rdy, control, control_val, busy, remaining
  );
endinterface

// File: rtl/xbar_route_sequencer_route_fifo.sv
// Circular route queue; pointers wrap modulo DEPTH, occupancy tracked separately
// so full/empty need no extra pointer bit.
module route_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == OW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/xbar_route_sequencer.sv
// Crossbar route sequencer: queues route requests, issues one control word per
// route, then counts the route's messages through the crossbar.
//
//   state  | meaning
//   IDLE   | no route in flight; pops the queue head when one is waiting
//   ISSUE  | control word presented, waiting for control_rdy
//   ACTIVE | path established, counting xfer_fire down to zero
module xbar_route_sequencer
  import xbar_seq_pkg::*;
#(
  parameter int N_INPUTS          = 2,
  parameter int N_OUTPUTS         = 2,
  parameter int CONTROL_BIT_WIDTH = 42,
  parameter int CNT_WIDTH         = 8,
  parameter int DEPTH             = 4
) (
  input logic                   clk,
  input logic                   reset,
  xbar_route_sequencer_if.slave bus
);
  localparam int IW = field_w(N_INPUTS);
  localparam int OW = field_w(N_OUTPUTS);
  localparam int MW = IW + OW + CNT_WIDTH;

  logic                         push;
  logic                         pop;
  logic                         full;
  logic                         empty;
  logic [MW-1:0]                head;
  logic [31:0]                  in_sel;
  logic [31:0]                  out_sel;
  logic [CONTROL_BIT_WIDTH-1:0] ctrl_next;

  seq_state_e                   state;
  logic [CNT_WIDTH-1:0]         route_cnt;
  logic [CNT_WIDTH-1:0]         remaining_q;
  logic [CONTROL_BIT_WIDTH-1:0] control_q;
  logic                         control_val_q;

  assign push = bus.route_val && !full;
  assign pop  = (state == IDLE) && !empty;

  route_fifo #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.route_msg),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign in_sel    = 32'(head[MW-1 -: IW]);
  assign out_sel   = 32'(head[CNT_WIDTH +: OW]);
  assign ctrl_next = CONTROL_BIT_WIDTH'(pack_control(CONTROL_BIT_WIDTH, IW, OW, in_sel, out_sel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      route_cnt     <= '0;
      remaining_q   <= '0;
      control_q     <= '0;
      control_val_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            route_cnt     <= head[CNT_WIDTH-1:0];
            control_q     <= ctrl_next;
            control_val_q <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.control_rdy) begin
            control_val_q <= 1'b0;
            if (route_cnt == '0) begin
              state <= IDLE;
            end else begin
              remaining_q <= route_cnt;
              state       <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (bus.xfer_fire) begin
            remaining_q <= remaining_q - CNT_WIDTH'(1);
            if (remaining_q == CNT_WIDTH'(1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.route_rdy   = !full;
  assign bus.control     = control_q;
  assign bus.control_val = control_val_q;
  assign bus.remaining   = remaining_q;
  assign bus.busy        = (state != IDLE) || !empty;
endmodule

// File: tb/tb_xbar_route_sequencer.sv
// Self-checking bench for xbar_route_sequencer: directed sequences, a vector
// table and a randomized run, all scored against a route-level queue model.
module tb_xbar_route_sequencer;
  localparam int CW    = 42;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  xbar_route_sequencer_if #(
    .N_INPUTS (2), .N_OUTPUTS (2), .CONTROL_BIT_WIDTH (CW), .CNT_WIDTH (8)
  ) bus ();

  xbar_route_sequencer #(
    .N_INPUTS (2), .N_OUTPUTS (2), .CONTROL_BIT_WIDTH (CW), .CNT_WIDTH (8), .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ctrl;
    int          cnt;
  } exp_t;

  typedef struct {
    int          in_s;
    int          out_s;
    int          cnt;
    int          dly;
    logic [63:0] ctrl;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   issued = 0;
  exp_t exp_q[$];
  bit   m_active = 0;
  int   m_rem = 0;
  bit   hold = 0;
  logic [63:0] held_ctrl = '0;
  int   cur_in = 0, cur_out = 0, cur_cnt = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Control word straight from the field layout: input_sel on bit 41, output_sel on bit 40.
  function automatic logic [63:0] exp_ctrl(int in_s, int out_s);
    return (64'(in_s) << (CW - 1)) | (64'(out_s) << (CW - 2));
  endfunction

  task automatic set_route(int in_s, int out_s, int cnt);
    logic [7:0] c;
    c       = 8'(cnt);
    cur_in  = in_s;
    cur_out = out_s;
    cur_cnt = cnt;
    bus.route_msg = {in_s[0], out_s[0], c};
  endtask

  // One clock: score the handshakes that happen at the coming edge, then check state after it.
  task automatic step();
    exp_t e;
    if (!reset) begin
      if (bus.control_val && bus.control_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_control: got 0x%0h expected no issue at %0t", bus.control, $time);
        end else begin
          e = exp_q.pop_front();
          chk("issue_order", 64'(bus.control), e.ctrl);
          issued++;
          if (e.cnt != 0) begin
            m_active = 1;
            m_rem    = e.cnt;
          end
        end
      end else if (m_active && bus.xfer_fire) begin
        m_rem--;
        if (m_rem == 0) m_active = 0;
      end
      if (bus.route_val && bus.route_rdy) begin
        e.ctrl = exp_ctrl(cur_in, cur_out);
        e.cnt  = cur_cnt;
        exp_q.push_back(e);
      end
      hold      = bus.control_val && !bus.control_rdy;
      held_ctrl = 64'(bus.control);
    end else begin
      exp_q.delete();
      m_active = 0;
      m_rem    = 0;
      hold     = 0;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      chk("remaining", 64'(bus.remaining), 64'(m_rem));
      chk("busy", 64'(bus.busy), 64'((exp_q.size() != 0) || m_active));
      if (hold) begin
        chk("ctrl_hold_val", 64'(bus.control_val), 64'(1));
        chk("ctrl_hold_word", 64'(bus.control), held_ctrl);
      end
    end
  endtask

  task automatic push_route(int in_s, int out_s, int cnt);
    int n;
    set_route(in_s, out_s, cnt);
    bus.route_val = 1'b1;
    n = 0;
    while (!bus.route_rdy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail_now("push_timeout");
    step();
    bus.route_val = 1'b0;
  endtask

  task automatic wait_cv();
    int n;
    n = 0;
    while (!bus.control_val && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) fail_now("wait_control_val");
  endtask

  vec_t vecs[4];

  initial begin
    int acc, n, n_push, cyc, issued0;

    vecs[0] = '{1, 0, 2, 0, 64'h200_0000_0000};
    vecs[1] = '{0, 1, 1, 3, 64'h100_0000_0000};
    vecs[2] = '{1, 1, 4, 1, 64'h300_0000_0000};
    vecs[3] = '{0, 0, 0, 2, 64'h000_0000_0000};

    reset = 1'b1;
    bus.route_val   = 1'b0;
    bus.route_msg   = '0;
    bus.control_rdy = 1'b0;
    bus.xfer_fire   = 1'b0;

    // Reset state
    #2;
    chk("rst_route_rdy", 64'(bus.route_rdy), 64'(1));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_control_val", 64'(bus.control_val), 64'(0));
    chk("rst_control", 64'(bus.control), 64'(0));
    chk("rst_remaining", 64'(bus.remaining), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Basic route: one-cycle issue, then count 3 -> 0
    bus.control_rdy = 1'b1;
    push_route(1, 0, 3);
    chk("lat_cv_early", 64'(bus.control_val), 64'(0));
    step();
    chk("lat_cv", 64'(bus.control_val), 64'(1));
    chk("basic_ctrl", 64'(bus.control), 64'h200_0000_0000);
    step();
    chk("basic_cv_one_cycle", 64'(bus.control_val), 64'(0));
    chk("basic_rem3", 64'(bus.remaining), 64'(3));
    bus.xfer_fire = 1'b1;
    step();
    chk("basic_rem2", 64'(bus.remaining), 64'(2));
    step();
    chk("basic_rem1", 64'(bus.remaining), 64'(1));
    step();
    bus.xfer_fire = 1'b0;
    chk("basic_rem0", 64'(bus.remaining), 64'(0));
    chk("basic_busy0", 64'(bus.busy), 64'(0));
    bus.control_rdy = 1'b0;

    // Vector table: route, handshake delay, expected control word
    for (int i = 0; i < 4; i++) begin
      push_route(vecs[i].in_s, vecs[i].out_s, vecs[i].cnt);
      wait_cv();
      chk("vec_ctrl", 64'(bus.control), vecs[i].ctrl);
      repeat (vecs[i].dly) step();
      bus.control_rdy = 1'b1;
      step();
      bus.control_rdy = 1'b0;
      chk("vec_rem_load", 64'(bus.remaining), 64'(vecs[i].cnt));
      bus.xfer_fire = 1'b1;
      repeat (vecs[i].cnt) step();
      bus.xfer_fire = 1'b0;
      chk("vec_busy_end", 64'(bus.busy), 64'(0));
      chk("vec_ctrl_held", 64'(bus.control), vecs[i].ctrl);
    end

    // Fill: one route sits in ISSUE, DEPTH more fill the queue
    bus.control_rdy = 1'b0;
    bus.xfer_fire   = 1'b0;
    bus.route_val   = 1'b1;
    acc = 0;
    n = 0;
    while (bus.route_rdy && n < 20) begin
      set_route(acc & 1, (acc >> 1) & 1, acc % 3);
      step();
      acc++;
      n++;
    end
    chk("fill_count", 64'(acc), 64'(DEPTH + 1));
    set_route(1, 1, 1);
    repeat (3) begin
      step();
      chk("full_route_rdy", 64'(bus.route_rdy), 64'(0));
    end
    bus.control_rdy = 1'b1;
    bus.xfer_fire   = 1'b1;
    n = 0;
    while (!bus.route_rdy && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) fail_now("fill_pop_wait");
    step();
    bus.route_val = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) fail_now("fill_drain");
    chk("fill_all_issued", 64'(exp_q.size()), 64'(0));
    bus.xfer_fire = 1'b0;

    // cnt=0 route: no ACTIVE, next route issued right after
    bus.control_rdy = 1'b1;
    push_route(0, 1, 0);
    push_route(1, 1, 2);
    chk("zero_ctrl", 64'(bus.control), 64'h100_0000_0000);
    step();
    chk("zero_cv_drop", 64'(bus.control_val), 64'(0));
    chk("zero_no_active", 64'(bus.remaining), 64'(0));
    step();
    chk("zero_next_cv", 64'(bus.control_val), 64'(1));
    chk("zero_next_ctrl", 64'(bus.control), 64'h300_0000_0000);
    bus.xfer_fire = 1'b1;
    repeat (3) step();
    bus.xfer_fire = 1'b0;
    chk("zero_busy_end", 64'(bus.busy), 64'(0));

    // xfer_fire during ISSUE is ignored
    bus.control_rdy = 1'b0;
    push_route(1, 0, 4);
    wait_cv();
    bus.xfer_fire = 1'b1;
    repeat (3) step();
    chk("issue_rem0", 64'(bus.remaining), 64'(0));
    bus.control_rdy = 1'b1;
    step();
    bus.control_rdy = 1'b0;
    bus.xfer_fire   = 1'b0;
    chk("issue_rem_cnt", 64'(bus.remaining), 64'(4));
    bus.xfer_fire = 1'b1;
    repeat (4) step();
    bus.xfer_fire = 1'b0;
    chk("issue_busy_end", 64'(bus.busy), 64'(0));

    // Reset mid-route with two routes queued
    bus.control_rdy = 1'b1;
    push_route(0, 1, 5);
    n = 0;
    while (bus.remaining != 8'd5 && n < 10) begin
      step();
      n++;
    end
    chk("mid_rem5", 64'(bus.remaining), 64'(5));
    bus.control_rdy = 1'b0;
    push_route(1, 0, 1);
    push_route(0, 0, 2);
    chk("mid_busy", 64'(bus.busy), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(bus.route_rdy), 64'(1));
    chk("mid_rst_cv", 64'(bus.control_val), 64'(0));
    chk("mid_rst_busy", 64'(bus.busy), 64'(0));
    chk("mid_rst_rem", 64'(bus.remaining), 64'(0));
    step();
    reset = 1'b0;
    bus.control_rdy = 1'b1;
    bus.xfer_fire   = 1'b1;
    repeat (6) begin
      step();
      chk("post_rst_cv", 64'(bus.control_val), 64'(0));
    end
    bus.xfer_fire = 1'b0;

    // Randomized: 10 routes, random handshake and transfer activity
    issued0 = issued;
    n_push = 0;
    cyc = 0;
    while ((n_push < 10 || bus.busy) && cyc < 3000) begin
      bus.control_rdy = 1'($urandom_range(0, 1));
      bus.xfer_fire   = 1'($urandom_range(0, 1));
      if (!(bus.route_val && !bus.route_rdy)) begin
        set_route($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
        bus.route_val = (n_push < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (bus.route_val && bus.route_rdy) n_push++;
      step();
      cyc++;
    end
    bus.route_val = 1'b0;
    if (cyc >= 3000) fail_now("rand_drain");
    chk("rand_issued", 64'(issued - issued0), 64'(10));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
